// File: rtl/smooth_pkg.sv
// Shared types and helpers for the button debounce block.
package smooth_pkg;

  // Which accepted transitions produce an event strobe.
  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_BOTH = 2'd2
  } edge_mode_e;

  // Legal parameter envelope.
  localparam int unsigned MIN_CHANNELS    = 1;
  localparam int unsigned MAX_CHANNELS    = 32;
  localparam int unsigned MIN_SYNC_STAGES = 2;
  localparam int unsigned MAX_SYNC_STAGES = 4;
  localparam int unsigned MIN_STABLE      = 1;
  localparam int unsigned MAX_STABLE      = 65535;

  // True when accepting new_level should raise the event strobe in this mode.
  function automatic logic edge_fires(input edge_mode_e mode, input logic new_level);
    logic fire;
    case (mode)
      EDGE_RISE: fire = new_level;
      EDGE_FALL: fire = !new_level;
      EDGE_BOTH: fire = 1'b1;
      default:   fire = 1'b0;
    endcase
    return fire;
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: synchroniser, stability counter, accepted level and
// event strobe. A new synchronised value is accepted only after it has
// differed from the accepted level for STABLE_CYCLES consecutive unmasked
// clocks; any return to the accepted level restarts the count from zero.
module debounce_chan
  import smooth_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 16,
  parameter edge_mode_e  EDGE_MODE     = EDGE_RISE
) (
  input  logic clk,
  input  logic reset,
  input  logic button_i,
  input  logic mask_i,
  output logic level_o,
  output logic pulse_o,
  output logic pulse_d_o
);

  localparam int unsigned      CNT_W    = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   pulse_q, pulse_d;

  assign synced = sync_q[SYNC_STAGES-1];

  // Synchroniser chain; runs regardless of mask so it is warm when unmasked.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every flop
      // samples the pre-edge value of its neighbours, giving a true shift.
      sync_q <= {sync_q[SYNC_STAGES-2:0], button_i};
    end
  end

  // Next-state logic for the stability counter, accepted level and strobe.
  always_comb begin
    // NOTE: every output of this block is assigned a default first so that
    // no path leaves it unassigned, which would otherwise infer a latch.
    cnt_d   = cnt_q;
    level_d = level_q;
    pulse_d = 1'b0;
    if (mask_i) begin
      cnt_d = '0;
    end else if (synced == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      level_d = synced;
      pulse_d = edge_fires(EDGE_MODE, synced);
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter, accepted level and strobe registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  assign level_o   = level_q;
  assign pulse_o   = pulse_q;
  assign pulse_d_o = pulse_d;

endmodule

// File: rtl/button_debounce.sv
// Multi-channel button debouncer: CHANNELS independent debounce channels plus
// a registered OR of all event strobes aligned with the strobes themselves.
module button_debounce
  import smooth_pkg::*;
#(
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 16,
  parameter edge_mode_e  EDGE_MODE     = EDGE_RISE
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] button,
  input  logic [CHANNELS-1:0] mask,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] pulse,
  output logic                pulse_any
);

  // Refuse to build with out-of-range parameters.
  if (CHANNELS < MIN_CHANNELS || CHANNELS > MAX_CHANNELS) begin : g_bad_channels
    $error("button_debounce: CHANNELS must be in 1..32");
  end
  if (SYNC_STAGES < MIN_SYNC_STAGES || SYNC_STAGES > MAX_SYNC_STAGES) begin : g_bad_sync
    $error("button_debounce: SYNC_STAGES must be in 2..4");
  end
  if (STABLE_CYCLES < MIN_STABLE || STABLE_CYCLES > MAX_STABLE) begin : g_bad_stable
    $error("button_debounce: STABLE_CYCLES must be in 1..65535");
  end
  if (!(EDGE_MODE inside {EDGE_RISE, EDGE_FALL, EDGE_BOTH})) begin : g_bad_mode
    $error("button_debounce: EDGE_MODE must be EDGE_RISE, EDGE_FALL or EDGE_BOTH");
  end

  logic [CHANNELS-1:0] pulse_next;
  logic                pulse_any_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    debounce_chan #(
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_CYCLES(STABLE_CYCLES),
      .EDGE_MODE    (EDGE_MODE)
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .button_i (button[i]),
      .mask_i   (mask[i]),
      .level_o  (level[i]),
      .pulse_o  (pulse[i]),
      .pulse_d_o(pulse_next[i])
    );
  end

  // Summary strobe registered from the channels' next-state strobes so it
  // lands in the same cycle as the per-channel pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pulse_any_q <= 1'b0;
    end else begin
      pulse_any_q <= |pulse_next;
    end
  end

  assign pulse_any = pulse_any_q;

endmodule
